// File: rtl/sw_score_tracker.sv
// rtl/sw_score_tracker.sv - best local-alignment score and position tracker over a row-major score stream
// Optional feature macro: SCORE_THRESHOLD_EN (adds threshold input and sticky hit output)
module sw_score_tracker #(
   parameter int DATA_WIDTH = 16,
   parameter int ROW_BITS   = 10,
   parameter int COL_BITS   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ROW_BITS-1:0]   num_rows,
   input  logic [COL_BITS-1:0]   num_cols,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_score,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] max_score,
   output logic [ROW_BITS-1:0]   max_row,
   output logic [COL_BITS-1:0]   max_col,
   output logic                  busy
`ifdef SCORE_THRESHOLD_EN
   ,
   input  logic [DATA_WIDTH-1:0] threshold,
   output logic                  hit
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [ROW_BITS-1:0] ROW_ONE = ROW_BITS'(1);
   localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);

   state_t state, state_nxt;

   logic [ROW_BITS-1:0] rows_q, row_cnt;
   logic [COL_BITS-1:0] cols_q, col_cnt;
   logic                accept, last_beat, start_go, dims_zero, col_wrap;

   // Sign-magnitude strict greater-than; -0 is treated as +0.
   function automatic logic sm_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-2:0] am, bm;
      logic                  an, bn;
      am = a[DATA_WIDTH-2:0];
      bm = b[DATA_WIDTH-2:0];
      an = a[DATA_WIDTH-1] && (am != '0);
      bn = b[DATA_WIDTH-1] && (bm != '0);
      if (an != bn)
         return bn;
      else if (!an)
         return am > bm;
      else
         return am < bm;
   endfunction

   assign start_go  = (state == S_IDLE) && start;
   assign dims_zero = (num_rows == '0) || (num_cols == '0);
   assign accept    = in_valid && (state == S_RUN);
   assign col_wrap  = (col_cnt == cols_q - COL_ONE);
   assign last_beat = col_wrap && (row_cnt == rows_q - ROW_ONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = dims_zero ? S_DONE : S_RUN;
         S_RUN:  if (accept && last_beat) state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_RUN);
      out_valid = (state == S_DONE);
      busy      = (state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rows_q    <= '0;
         cols_q    <= '0;
         row_cnt   <= '0;
         col_cnt   <= '0;
         max_score <= '0;
         max_row   <= '0;
         max_col   <= '0;
      end else if (start_go) begin
         rows_q    <= num_rows;
         cols_q    <= num_cols;
         row_cnt   <= '0;
         col_cnt   <= '0;
         max_score <= '0;
         max_row   <= '0;
         max_col   <= '0;
      end else if (accept) begin
         if (sm_gt(in_score, max_score)) begin
            max_score <= in_score;
            max_row   <= row_cnt;
            max_col   <= col_cnt;
         end
         // Counters park at zero after the last beat so they never run past the dims.
         if (last_beat) begin
            row_cnt <= '0;
            col_cnt <= '0;
         end else if (col_wrap) begin
            row_cnt <= row_cnt + ROW_ONE;
            col_cnt <= '0;
         end else begin
            col_cnt <= col_cnt + COL_ONE;
         end
      end
   end

`ifdef SCORE_THRESHOLD_EN
   logic [DATA_WIDTH-1:0] thr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thr_q <= '0;
         hit   <= 1'b0;
      end else if (start_go) begin
         thr_q <= threshold;
         hit   <= 1'b0;
      end else if (accept && !sm_gt(thr_q, in_score)) begin
         hit <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sw_score_tracker.sv
// tb/tb_sw_score_tracker.sv - self-checking bench for sw_score_tracker against an integer reference model
module tb_sw_score_tracker;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  num_rows;
   logic [9:0]  num_cols;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_score;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] max_score;
   logic [9:0]  max_row;
   logic [9:0]  max_col;
   logic        busy;
`ifdef SCORE_THRESHOLD_EN
   logic [15:0] threshold;
   logic        hit;
`endif

   int checks = 0;
   int errors = 0;
   logic [15:0] scores[$];

   always #5 clk = ~clk;

   sw_score_tracker dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
      .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
      .out_valid(out_valid), .out_ready(out_ready), .max_score(max_score),
      .max_row(max_row), .max_col(max_col), .busy(busy)
`ifdef SCORE_THRESHOLD_EN
      , .threshold(threshold), .hit(hit)
`endif
   );

   function automatic int sm2int(input logic [15:0] s);
      return s[15] ? -int'(s[14:0]) : int'(s[14:0]);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] rand_score();
      logic [15:0] s;
      s[15]    = 1'($urandom_range(0, 1));
      s[14:0]  = ($urandom_range(0, 9) == 0) ? 15'h7fff : 15'($urandom_range(0, 20));
      return s;
   endfunction

   task automatic run_job(input int rows, input int cols, input int vprob, input int hold);
      int          n, idx, cyc, best, er, ec;
      logic [15:0] es;
      logic        acc, eh;
      n = rows * cols;
      best = 0; es = 16'h0; er = 0; ec = 0; eh = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (sm2int(scores[i]) > best) begin
            best = sm2int(scores[i]);
            es = scores[i];
            er = i / cols;
            ec = i % cols;
         end
`ifdef SCORE_THRESHOLD_EN
         if (sm2int(scores[i]) >= sm2int(threshold)) eh = 1'b1;
`endif
      end
      chk("idle_before_start", busy, 1'b0);
      num_rows = 10'(rows);
      num_cols = 10'(cols);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
`ifdef SCORE_THRESHOLD_EN
      chk("hit_cleared", hit, 1'b0);
`endif
      if (n == 0) begin
         chk("zero_dims_done", out_valid, 1'b1);
         chk("zero_dims_in_ready", in_ready, 1'b0);
      end
      idx = 0; cyc = 0;
      while (idx < n && cyc < 2000) begin
         chk("run_in_ready", in_ready, 1'b1);
         chk("run_out_valid", out_valid, 1'b0);
         in_valid = ($urandom_range(0, 99) < vprob);
         in_score = in_valid ? scores[idx] : 16'($urandom);
         acc = in_valid;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (acc) idx++;
         cyc++;
      end
      chk("beats_consumed", idx, n);
      chk("done_out_valid", out_valid, 1'b1);
      chk("done_in_ready", in_ready, 1'b0);
      chk("max_score", max_score, es);
      chk("max_row", max_row, er);
      chk("max_col", max_col, ec);
`ifdef SCORE_THRESHOLD_EN
      chk("hit", hit, eh);
`endif
      for (int k = 0; k < hold; k++) begin
         out_ready = 1'b0;
         start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_busy", busy, 1'b1);
         chk("hold_max_score", max_score, es);
         chk("hold_max_row", max_row, er);
         chk("hold_max_col", max_col, ec);
      end
      // start held through the handshake cycle must not launch a new job
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("handshake_idle", busy, 1'b0);
      chk("handshake_out_valid", out_valid, 1'b0);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_rows = '0; num_cols = '0;
      in_valid = 1'b0; in_score = '0; out_ready = 1'b0;
`ifdef SCORE_THRESHOLD_EN
      threshold = 16'h7fff;
`endif
      #12;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_max_score", max_score, 16'h0);
      chk("rst_max_row", max_row, 10'h0);
      chk("rst_max_col", max_col, 10'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      scores = '{16'd3, 16'd7, 16'd2, 16'd5, 16'd7, 16'd1};
      run_job(2, 3, 100, 0);

      scores = '{};
      run_job(0, 4, 100, 0);

      scores = '{16'h8005, 16'h8002, 16'h8009, 16'h8002};
      run_job(1, 4, 100, 0);

      scores = '{16'd9, 16'd4, 16'd11, 16'h8000};
      run_job(2, 2, 50, 5);

      // reset in the middle of a 3x3 job
      num_rows = 10'd3; num_cols = 10'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_score = 16'(20 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_max_score", max_score, 16'h0);
      chk("midrst_max_row", max_row, 10'h0);
      chk("midrst_max_col", max_col, 10'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      scores = '{16'd4};
      run_job(1, 1, 100, 0);

`ifdef SCORE_THRESHOLD_EN
      threshold = 16'd10;
      scores = '{16'd4, 16'd10, 16'd12, 16'd3, 16'd0};
      run_job(1, 5, 100, 2);
`endif

      for (int j = 0; j < 15; j++) begin
         int r, c;
         r = $urandom_range(1, 4);
         c = $urandom_range(1, 5);
         scores = '{};
         for (int i = 0; i < r * c; i++) scores.push_back(rand_score());
`ifdef SCORE_THRESHOLD_EN
         threshold = rand_score();
`endif
         run_job(r, c, $urandom_range(40, 100), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
